// File: rtl/xbar_l2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_l2_pkg
// Description : Shared types, constants and helpers for the XBAR_L2
//               request-side arbitration blocks.
//               - RESP_LAT_MAX   : deepest supported bank response latency
//               - N_MASTER_MAX   : widest supported initiator count
//               - TAG_IDX_WIDTH  : index width of a response tag
//               - resp_tag_t     : {vld, idx} tag carried by the response pipe
//               - log2_min1()    : index width for n entries, never below 1
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_l2_pkg;

    localparam int RESP_LAT_MAX  = 4;
    localparam int N_MASTER_MAX  = 16;
    localparam int TAG_IDX_WIDTH = 4;

    // Tag index is sized for the widest configuration so one tag type can be
    // shared by every arbiter instance; narrower winners are zero-extended.
    typedef struct packed {
        logic                     vld;
        logic [TAG_IDX_WIDTH-1:0] idx;
    } resp_tag_t;

    // A single-entry index still needs one physical bit.
    function automatic int log2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : xbar_l2_pkg
`default_nettype wire

// File: rtl/rr_arbiter_l2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_l2
// Description : Pure combinational round-robin priority picker. The first
//               requester at or above ptr wins; if none, the search wraps and
//               the lowest requester wins.
// Ports       : req    in  N      request vector
//               ptr    in  IDX_W  highest-priority index (must be < N)
//               gnt    out N      one-hot winner (all zero when no request)
//               winner out IDX_W  winner index (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_l2
    import xbar_l2_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = log2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner
);

    generate
        if (N == 1) begin : g_single
            logic w_unused_ptr;
            assign w_unused_ptr = ^ptr;
            assign gnt          = req;
            assign winner       = '0;
        end else begin : g_multi
            logic [N-1:0] w_mask;
            logic [N-1:0] w_hi;
            logic [N-1:0] w_sel;

            // Requests at or above the pointer take priority; if there are
            // none the plain request vector supplies the wrapped search.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    w_mask[i] = (i >= int'(ptr));
                end
                w_hi  = req & w_mask;
                w_sel = (|w_hi) ? w_hi : req;
            end

            // Scan downward so the lowest set bit of w_sel is the last write.
            always_comb begin
                gnt    = '0;
                winner = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (w_sel[i]) begin
                        winner = IDX_W'(i);
                        gnt    = '0;
                        gnt[i] = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule : rr_arbiter_l2
`default_nettype wire

// File: rtl/request_arb_tree_l2.sv
`default_nettype none
// ============================================================================
// Module      : request_arb_tree_l2
// Description : Round-robin arbitration of N_MASTER TCDM request ports onto a
//               single L2 bank port. Each handshake is tagged into a
//               RESP_LAT-deep pipeline that steers the bank response valid
//               back to the granted master; read data is broadcast.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               data_req_i   [N]      per-master request
//               data_add_i   [N*AW]   per-master address (master 0 in LSBs)
//               data_wen_i   [N]      per-master write enable (1 = read)
//               data_wdata_i [N*DW]   per-master write data
//               data_be_i    [N*BW]   per-master byte enables
//               data_gnt_o   [N]      per-master grant
//               data_r_valid_o [N]    per-master response valid
//               data_r_rdata_o [DW]   read data to all masters
//               data_req_o/add/wen/wdata/be_o   bank request payload
//               data_gnt_i            bank ready
//               data_r_rdata_i [DW]   bank read data
// Revision    : 1.0 - initial release
// ============================================================================
module request_arb_tree_l2
    import xbar_l2_pkg::*;
#(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RESP_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    input  logic                           data_gnt_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i
);

    localparam int c_IDX_W = log2_min1(N_MASTER);

    logic [c_IDX_W-1:0]    w_ptr;
    logic [c_IDX_W-1:0]    w_winner;
    logic [N_MASTER-1:0]   w_arb_gnt;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_add;
    logic                  w_wen;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_be;
    resp_tag_t             w_tag;
    resp_tag_t             r_pipe [RESP_LAT];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter_l2 #(
        .N     (N_MASTER),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req    (data_req_i),
        .ptr    (w_ptr),
        .gnt    (w_arb_gnt),
        .winner (w_winner)
    );

    // Every output is forced low while reset is held, including the purely
    // combinational request path.
    assign data_req_o = rst_n & (|data_req_i);
    assign data_gnt_o = w_arb_gnt & {N_MASTER{rst_n & data_gnt_i}};
    assign w_hs       = data_req_o & data_gnt_i;

    // ------------------------------------------------------------------
    // Round-robin pointer
    // ------------------------------------------------------------------
    generate
        if (N_MASTER == 1) begin : g_ptr_single
            assign w_ptr = '0;
        end else begin : g_ptr_multi
            logic [c_IDX_W-1:0] r_rr_ptr;
            logic [c_IDX_W-1:0] w_ptr_nxt;

            // Explicit wrap compare: N_MASTER need not be a power of two.
            assign w_ptr_nxt = (w_winner == c_IDX_W'(N_MASTER - 1)) ?
                               '0 : (w_winner + 1'b1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rr_ptr <= '0;
                end else if (w_hs) begin
                    r_rr_ptr <= w_ptr_nxt;
                end
            end

            assign w_ptr = r_rr_ptr;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Payload mux. With no requester the winner index is 0, so the bank
    // sees master 0's payload rather than X.
    // ------------------------------------------------------------------
    always_comb begin
        w_add   = data_add_i[0 +: ADDR_WIDTH];
        w_wen   = data_wen_i[0];
        w_wdata = data_wdata_i[0 +: DATA_WIDTH];
        w_be    = data_be_i[0 +: BE_WIDTH];
        for (int i = 1; i < N_MASTER; i++) begin
            if (w_winner == c_IDX_W'(i)) begin
                w_add   = data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wen   = data_wen_i[i];
                w_wdata = data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_be    = data_be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign data_add_o     = w_add & {ADDR_WIDTH{rst_n}};
    assign data_wen_o     = w_wen & rst_n;
    assign data_wdata_o   = w_wdata & {DATA_WIDTH{rst_n}};
    assign data_be_o      = w_be & {BE_WIDTH{rst_n}};
    assign data_r_rdata_o = data_r_rdata_i & {DATA_WIDTH{rst_n}};

    // ------------------------------------------------------------------
    // Response pipeline: one tag per cycle, shifted RESP_LAT times. Reads
    // and writes both produce a response.
    // ------------------------------------------------------------------
    always_comb begin
        w_tag     = '0;
        w_tag.vld = w_hs;
        w_tag.idx = TAG_IDX_WIDTH'(w_winner);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RESP_LAT; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= w_tag;
            for (int s = 1; s < RESP_LAT; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_rvalid
            assign data_r_valid_o[gi] = r_pipe[RESP_LAT-1].vld &&
                                        (r_pipe[RESP_LAT-1].idx == TAG_IDX_WIDTH'(gi));
        end
    endgenerate

endmodule : request_arb_tree_l2
`default_nettype wire

// File: tb/tb_request_arb_tree_l2.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_arb_tree_l2
// Description : Self-checking bench. Two instances share stimulus:
//               dut_a (N_MASTER=4, RESP_LAT=3) and dut_b (N_MASTER=3,
//               RESP_LAT=1, non-power-of-two). A reference model picks the
//               winner from the round-robin rule and schedules expected
//               response valids by absolute cycle number.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_arb_tree_l2;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int BW   = 8;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    req = '0;
    logic [AW-1:0] add   [4];
    logic [3:0]    wen = '0;
    logic [DW-1:0] wdata [4];
    logic [BW-1:0] be    [4];
    logic          bank_gnt = 1'b0;
    logic [DW-1:0] bank_rdata = '0;

    logic [4*AW-1:0] add_a;
    logic [4*DW-1:0] wdata_a;
    logic [4*BW-1:0] be_a;
    logic [3*AW-1:0] add_b;
    logic [3*DW-1:0] wdata_b;
    logic [3*BW-1:0] be_b;
    assign add_a   = {add[3], add[2], add[1], add[0]};
    assign wdata_a = {wdata[3], wdata[2], wdata[1], wdata[0]};
    assign be_a    = {be[3], be[2], be[1], be[0]};
    assign add_b   = {add[2], add[1], add[0]};
    assign wdata_b = {wdata[2], wdata[1], wdata[0]};
    assign be_b    = {be[2], be[1], be[0]};

    logic [3:0]    gnt_a, rv_a;
    logic [DW-1:0] rdata_a, wdata_o_a;
    logic          req_o_a, wen_o_a;
    logic [AW-1:0] add_o_a;
    logic [BW-1:0] be_o_a;

    logic [2:0]    gnt_b, rv_b;
    logic [DW-1:0] rdata_b, wdata_o_b;
    logic          req_o_b, wen_o_b;
    logic [AW-1:0] add_o_b;
    logic [BW-1:0] be_o_b;

    request_arb_tree_l2 #(
        .N_MASTER(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RESP_LAT(LAT_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_add_i(add_a), .data_wen_i(wen),
        .data_wdata_i(wdata_a), .data_be_i(be_a),
        .data_gnt_o(gnt_a), .data_r_valid_o(rv_a), .data_r_rdata_o(rdata_a),
        .data_req_o(req_o_a), .data_add_o(add_o_a), .data_wen_o(wen_o_a),
        .data_wdata_o(wdata_o_a), .data_be_o(be_o_a),
        .data_gnt_i(bank_gnt), .data_r_rdata_i(bank_rdata)
    );

    request_arb_tree_l2 #(
        .N_MASTER(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RESP_LAT(LAT_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req[2:0]), .data_add_i(add_b), .data_wen_i(wen[2:0]),
        .data_wdata_i(wdata_b), .data_be_i(be_b),
        .data_gnt_o(gnt_b), .data_r_valid_o(rv_b), .data_r_rdata_o(rdata_b),
        .data_req_o(req_o_b), .data_add_o(add_o_b), .data_wen_o(wen_o_b),
        .data_wdata_o(wdata_o_b), .data_be_o(be_o_b),
        .data_gnt_i(bank_gnt), .data_r_rdata_i(bank_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         ptr_a = 0;
    int         ptr_b = 0;
    int         cyc   = 0;
    logic [3:0] due_a [int];
    logic [3:0] due_b [int];

    // Round-robin rule: first requester scanning upward from p, modulo n.
    function automatic int pick(input logic [3:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (p + k) % n;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] due_at(input logic [3:0] q [int], input int c);
        return q.exists(c) ? q[c] : 4'd0;
    endfunction

    task automatic step(input logic [3:0] r, input logic g, input logic do_rst);
        int         wa, wb, ma, mb;
        logic [3:0] exp_g;
        @(negedge clk);
        rst_n      = ~do_rst;
        req        = r;
        bank_gnt   = g;
        bank_rdata = {$urandom, $urandom};
        for (int m = 0; m < 4; m++) begin
            add[m]   = $urandom;
            wen[m]   = 1'($urandom_range(0, 1));
            wdata[m] = {$urandom, $urandom};
            be[m]    = 8'($urandom);
        end
        #2;
        if (do_rst) begin
            ptr_a = 0;
            ptr_b = 0;
            due_a.delete();
            due_b.delete();
            check_val("rst_gnt_a",   64'(gnt_a),   64'd0);
            check_val("rst_rv_a",    64'(rv_a),    64'd0);
            check_val("rst_req_a",   64'(req_o_a), 64'd0);
            check_val("rst_add_a",   64'(add_o_a), 64'd0);
            check_val("rst_rdata_a", rdata_a,      64'd0);
            check_val("rst_gnt_b",   64'(gnt_b),   64'd0);
            check_val("rst_rv_b",    64'(rv_b),    64'd0);
            check_val("rst_req_b",   64'(req_o_b), 64'd0);
        end else begin
            // ---------------- instance A (N=4) ----------------
            wa    = pick(r, ptr_a, 4);
            ma    = (wa < 0) ? 0 : wa;
            exp_g = (wa >= 0 && g) ? (4'd1 << wa) : 4'd0;
            check_val("a_req",   64'(req_o_a),   64'(|r));
            check_val("a_gnt",   64'(gnt_a),     64'(exp_g));
            check_val("a_add",   64'(add_o_a),   64'(add[ma]));
            check_val("a_wen",   64'(wen_o_a),   64'(wen[ma]));
            check_val("a_wdata", wdata_o_a,      wdata[ma]);
            check_val("a_be",    64'(be_o_a),    64'(be[ma]));
            check_val("a_rv",    64'(rv_a),      64'(due_at(due_a, cyc)));
            check_val("a_rdata", rdata_a,        bank_rdata);
            due_a.delete(cyc);
            if (wa >= 0 && g) begin
                ptr_a = (wa + 1) % 4;
                due_a[cyc + LAT_A] = 4'd1 << wa;
            end
            // ---------------- instance B (N=3) ----------------
            wb    = pick(r & 4'b0111, ptr_b, 3);
            mb    = (wb < 0) ? 0 : wb;
            exp_g = (wb >= 0 && g) ? (4'd1 << wb) : 4'd0;
            check_val("b_req",   64'(req_o_b),   64'(|r[2:0]));
            check_val("b_gnt",   64'(gnt_b),     64'(exp_g));
            check_val("b_add",   64'(add_o_b),   64'(add[mb]));
            check_val("b_wen",   64'(wen_o_b),   64'(wen[mb]));
            check_val("b_be",    64'(be_o_b),    64'(be[mb]));
            check_val("b_rv",    64'(rv_b),      64'(due_at(due_b, cyc)));
            check_val("b_rdata", rdata_b,        bank_rdata);
            due_b.delete(cyc);
            if (wb >= 0 && g) begin
                ptr_b = (wb + 1) % 3;
                due_b[cyc + LAT_B] = 4'd1 << wb;
            end
        end
        cyc++;
    endtask

    initial begin
        for (int m = 0; m < 4; m++) begin
            add[m]   = '0;
            wdata[m] = '0;
            be[m]    = '0;
        end

        // Reset state
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);

        // Single requester, then idle while its response returns
        step(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Full contention
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0);

        // Bank stall with masters 1 and 3 requesting
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);

        // Back-to-back handshakes for masters 0,1,2 then drain
        step(4'b0111, 1'b1, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Reset while a response is in flight
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Randomized traffic with occasional stalls and resets
        for (int i = 0; i < 500; i++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_request_arb_tree_l2
`default_nettype wire

// File: doc/request_arb_tree_l2.md
Name: request_arb_tree_l2

Overview:
- Request-side counterpart of the L2 crossbar response fan-in.
- Arbitrates N_MASTER TCDM-style request ports onto one L2 bank port with round-robin fairness.
- Records each grant in a fixed-latency pipeline and steers the bank's read data and response valid back to the granted master.
- One instance sits in front of each L2 bank inside XBAR_L2.

Parameters:
- N_MASTER, 4, number of initiator ports (1..16).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 64, write/read data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- RESP_LAT, 1, bank response latency in cycles after the handshake (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- data_req_i  in  N_MASTER  per-master request.
- data_add_i  in  N_MASTER x ADDR_WIDTH  per-master address.
- data_wen_i  in  N_MASTER  per-master write enable (1 = read, 0 = write).
- data_wdata_i  in  N_MASTER x DATA_WIDTH  per-master write data.
- data_be_i  in  N_MASTER x BE_WIDTH  per-master byte enables.
- data_gnt_o  out  N_MASTER  per-master grant.
- data_r_valid_o  out  N_MASTER  per-master response valid.
- data_r_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters.
- data_req_o  out  1  bank request.
- data_add_o  out  ADDR_WIDTH  bank address.
- data_wen_o  out  1  bank write enable.
- data_wdata_o  out  DATA_WIDTH  bank write data.
- data_be_o  out  BE_WIDTH  bank byte enables.
- data_gnt_i  in  1  bank ready.
- data_r_rdata_i  in  DATA_WIDTH  bank read data, valid RESP_LAT cycles after a handshake.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active low.
- State:
  - rr_ptr_q: log2(N_MASTER) bits, reset 0.
  - Response pipeline: RESP_LAT stages of {vld, idx}, all vld reset 0.
- Request path (combinational):
  - data_req_o = OR of data_req_i.
  - Winner = first requesting master scanning upward from rr_ptr_q, wrapping modulo N_MASTER.
  - data_add_o, data_wen_o, data_wdata_o and data_be_o are muxed from the winner.
  - When no master requests, the payload outputs are don't-care but driven from master 0, so no X appears.
- Grant:
  - data_gnt_o[i] = data_req_i[i] & (i == winner) & data_gnt_i. At most one bit is set.
  - No grant goes to a non-requesting master.
- Handshake = data_req_o & data_gnt_i.
  - On a handshake, rr_ptr_q <= (winner + 1) mod N_MASTER.
  - Otherwise rr_ptr_q holds. The pointer never advances on an ungranted cycle.
- Response pipeline:
  - Stage 0 captures {handshake, winner} every cycle; each later stage shifts by one per cycle.
  - data_r_valid_o[i] = last_stage.vld & (last_stage.idx == i).
  - Responses are generated for both reads and writes.
  - data_r_rdata_o = data_r_rdata_i, passed through combinationally.
- Latency:
  - Grant: 0 cycles after the request.
  - r_valid: exactly RESP_LAT cycles after the grant cycle.
- Throughput: back-to-back handshakes every cycle. The pipeline holds up to RESP_LAT outstanding responses with no stall.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0,... Worst-case wait is N_MASTER-1 handshakes.
- Bank stall: while data_gnt_i is low, all grants are low, the pointer holds, and the request payload stays on the winner.
- N_MASTER == 1: the block is a pass-through. rr_ptr is constant 0 and only the response pipeline remains.
- Reset mid-operation: pointer returns to 0 and all pipeline vld bits clear. In-flight responses are dropped (no r_valid is emitted) and all outputs are 0 while rst_n is low.
- Width rule: winner and idx are $clog2(N_MASTER) bits, minimum 1. Pointer wrap uses an explicit compare with N_MASTER-1, since N_MASTER need not be a power of two.

Decomposition:
- Shared package xbar_l2_pkg holds:
  - function log2_min1(n);
  - localparam RESP_LAT_MAX = 4;
  - packed struct type template for the {vld, idx} response tag.
- One sub-module, rr_arbiter_l2: a pure round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot gnt, winner index.
  - Reusable by other XBAR_L2 arbitration blocks.
- Pointer register, payload mux and response pipeline stay in request_arb_tree_l2.

Test Plan:
- Single requester: N=4, RESP_LAT=1, master 2 reads addr 0x100, data_gnt_i=1 -> gnt_o=0100 the same cycle, data_add_o=0x100; next cycle r_valid_o=0100 with rdata_o = bank data.
- Full contention: all 4 masters request for 8 cycles, gnt_i=1 -> grant order 0,1,2,3,0,1,2,3; r_valid_o follows the same order delayed 1 cycle.
- Bank stall: masters 1 and 3 request, gnt_i held 0 for 3 cycles then 1 -> gnt_o=0 during the stall and the pointer does not move; master 1 granted first, then master 3.
- Pipelined latency: RESP_LAT=3, masters 0,1,2 each granted on consecutive cycles -> r_valid_o = 0001, 0010, 0100 on cycles +3, +4, +5 with no gaps.
- Reset mid-flight: RESP_LAT=2, grant master 3, assert rst_n low the next cycle -> no r_valid_o ever for master 3; after release, the first grant with all requesting goes to master 0.
- Non-power-of-two: N=3, all requesting for 6 cycles -> grant order 0,1,2,0,1,2; the pointer never reaches 3.
